// File: rtl/data_bus_arbiter_pkg.sv
// Address map, region encoding and FSM state types shared by the data bus arbiter.
package data_bus_arbiter_pkg;

  localparam logic [31:0] QUAD_MASK     = 32'hC000_0000;
  localparam logic [31:0] RAM_BASE_ADDR = 32'h0000_0000;
  localparam logic [31:0] IO_BASE_ADDR  = 32'hC000_0000;

  typedef enum logic [1:0] {
    REGION_RAM      = 2'd0,
    REGION_IO       = 2'd1,
    REGION_UNMAPPED = 2'd2
  } region_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_IO_WAIT = 1'b1
  } arb_state_t;

  function automatic region_t decode_region(input logic [31:0] addr);
    region_t r;
    if ((addr & QUAD_MASK) == RAM_BASE_ADDR)     r = REGION_RAM;
    else if ((addr & QUAD_MASK) == IO_BASE_ADDR) r = REGION_IO;
    else                                         r = REGION_UNMAPPED;
    return r;
  endfunction

endpackage

// File: rtl/data_bus_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; on a tie the master not granted last wins.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic last_m1;

  always_comb begin
    gnt = '0;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_m1 ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  // Reset to "m1 last" so m0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      last_m1 <= 1'b1;
    else if (|gnt) last_m1 <= gnt[1];
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter routing transfers to RAM or a wait-stated IO bus.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned IO_WAIT = 2,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              ram_we,
  output logic [31:0]       ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              bus_we,
  output logic [31:0]       bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam logic [3:0] WAIT_LOAD = 4'(IO_WAIT);
  localparam bit         HAS_WAIT  = (IO_WAIT != 0);

  arb_state_t        state, state_nxt;
  logic [3:0]        wait_cnt;
  logic [1:0]        gnt;
  logic              grant, sel_m1, sel_we, io_stall;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  region_t           sel_region;
  logic [31:0]       hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic              owner_q, we_q, rvalid_q;
  region_t           region_q;
  logic [DATA_W-1:0] resp_data;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    ({m1_req, m0_req}),
    .enable ((state == ST_IDLE) && rst),
    .gnt    (gnt)
  );

  always_comb begin
    grant      = |gnt;
    sel_m1     = gnt[1];
    sel_we     = sel_m1 ? m1_we    : m0_we;
    sel_addr   = sel_m1 ? m1_addr  : m0_addr;
    sel_wdata  = sel_m1 ? m1_wdata : m0_wdata;
    sel_region = decode_region(sel_addr);
    io_stall   = grant && (sel_region == REGION_IO) && HAS_WAIT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (io_stall) state_nxt = ST_IO_WAIT;
      ST_IO_WAIT: if (wait_cnt <= 4'd1) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // The response pulse fires one cycle after a plain grant, or on the cycle
  // after the IO wait counter expires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt   <= '0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      region_q   <= REGION_RAM;
      rvalid_q   <= 1'b0;
    end else begin
      rvalid_q <= (grant && !io_stall) || ((state == ST_IO_WAIT) && (wait_cnt <= 4'd1));
      if (grant) begin
        owner_q    <= sel_m1;
        we_q       <= sel_we;
        region_q   <= sel_region;
        hold_addr  <= sel_addr;
        hold_wdata <= sel_wdata;
      end
      if (io_stall)                                  wait_cnt <= WAIT_LOAD;
      else if (state == ST_IO_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_comb begin
    m0_gnt    = gnt[0];
    m1_gnt    = gnt[1];
    ram_we    = grant && (sel_region == REGION_RAM) && sel_we;
    ram_addr  = sel_addr;
    ram_wdata = sel_wdata;
    bus_we    = grant && (sel_region == REGION_IO) && sel_we;
    bus_addr  = (state == ST_IO_WAIT) ? hold_addr  : sel_addr;
    bus_wdata = (state == ST_IO_WAIT) ? hold_wdata : sel_wdata;

    resp_data = '0;
    if (rvalid_q && !we_q) begin
      case (region_q)
        REGION_RAM: resp_data = ram_rdata;
        REGION_IO:  resp_data = bus_rdata;
        default:    resp_data = '0;
      endcase
    end

    m0_rvalid = rvalid_q && !owner_q;
    m1_rvalid = rvalid_q &&  owner_q;
    m0_rdata  = m0_rvalid ? resp_data : '0;
    m1_rdata  = m1_rvalid ? resp_data : '0;
    m0_err    = m0_rvalid && (region_q == REGION_UNMAPPED);
    m1_err    = m1_rvalid && (region_q == REGION_UNMAPPED);
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed scenarios plus a randomized transaction-level model.
module tb_data_bus_arbiter;

  localparam int IO_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we, bus_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata, bus_addr, bus_wdata, bus_rdata;

  logic [31:0] mem [16];
  logic [31:0] model_mem [16];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          due;
    int          m;
    logic [31:0] data;
    logic        err;
  } resp_t;

  data_bus_arbiter #(.IO_WAIT(IO_WAIT), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_init(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h1234_0000 + 32'(i) * 32'h111;
  endfunction

  function automatic logic [31:0] io_value(input logic [31:0] a);
    return {a[15:0], 16'hB0B0};
  endfunction

  // 16-word RAM with one-cycle read latency; contents restored while reset is low.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= ram_init(i);
    end else if (ram_we) begin
      mem[ram_addr[5:2]] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr[5:2]];
  end

  always @(posedge clk) bus_rdata <= io_value(bus_addr);

  task automatic init_shadow;
    for (int i = 0; i < 16; i++) model_mem[i] = ram_init(i);
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    init_shadow();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0; m0_wdata = 32'h1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hC000_0000; m1_wdata = 32'h2;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_bad++; $display("FAIL rst_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
    n_cmp++; if ({ram_we, bus_we} !== 2'b00) begin n_bad++; $display("FAIL rst_we: got %b want 00", {ram_we, bus_we}); end
    n_cmp++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0) begin n_bad++; $display("FAIL rst_resp: got %b want 0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
    n_cmp++; if ((m0_rdata | m1_rdata) !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", m0_rdata | m1_rdata); end
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0; rst = 1'b1;
    init_shadow();
  endtask

  task automatic test_ram_read;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010; #1;
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_bad++; $display("FAIL rd_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
    n_cmp++; if (ram_addr !== 32'h10) begin n_bad++; $display("FAIL rd_addr: got %h want 00000010", ram_addr); end
    n_cmp++; if ({ram_we, bus_we} !== 2'b00) begin n_bad++; $display("FAIL rd_we: got %b want 00", {ram_we, bus_we}); end
    @(negedge clk);
    m0_req = 1'b0; #1;
    n_cmp++; if (m0_rvalid !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid: got %b want 1", m0_rvalid); end
    n_cmp++; if (m0_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", m0_rdata); end
    n_cmp++; if ({m1_rvalid, m1_err, m0_err} !== 3'b0 || m1_rdata !== 32'h0) begin n_bad++; $display("FAIL rd_m1_quiet: got %b/%h want 000/0", {m1_rvalid, m1_err, m0_err}, m1_rdata); end
    @(negedge clk); #1;
    n_cmp++; if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_single_pulse: got %b want 0", m0_rvalid); end
  endtask

  task automatic test_tie;
    apply_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8; #1;
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_bad++; $display("FAIL tie_first: got %b want 10", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    m0_req = 1'b0; #1;
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_bad++; $display("FAIL tie_second: got %b want 01", {m0_gnt, m1_gnt}); end
    n_cmp++; if (m0_rvalid !== 1'b1 || m0_rdata !== model_mem[1]) begin n_bad++; $display("FAIL tie_m0_resp: got %b/%h want 1/%h", m0_rvalid, m0_rdata, model_mem[1]); end
    @(negedge clk);
    m0_req = 1'b1; #1;
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_bad++; $display("FAIL tie_rr_m0: got %b want 10", {m0_gnt, m1_gnt}); end
    n_cmp++; if (m1_rvalid !== 1'b1 || m1_rdata !== model_mem[2]) begin n_bad++; $display("FAIL tie_m1_resp: got %b/%h want 1/%h", m1_rvalid, m1_rdata, model_mem[2]); end
    @(negedge clk);
    m0_req = 1'b0; #1;
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_bad++; $display("FAIL tie_rr_m1: got %b want 01", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    m1_req = 1'b0;
  endtask

  task automatic test_io_write;
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hC000_0004; m1_wdata = 32'h55; #1;
    n_cmp++; if ({m1_gnt, bus_we, ram_we} !== 3'b110) begin n_bad++; $display("FAIL io_grant: got %b want 110", {m1_gnt, bus_we, ram_we}); end
    n_cmp++; if (bus_addr !== 32'hC000_0004 || bus_wdata !== 32'h55) begin n_bad++; $display("FAIL io_bus_T: got %h/%h want c0000004/55", bus_addr, bus_wdata); end
    for (int k = 1; k <= IO_WAIT; k++) begin
      @(negedge clk);
      m1_req = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'hFFFF; #1;
      n_cmp++; if ({m0_gnt, m1_gnt, bus_we, ram_we} !== 4'b0) begin n_bad++; $display("FAIL io_wait_quiet: cycle %0d got %b want 0000", k, {m0_gnt, m1_gnt, bus_we, ram_we}); end
      n_cmp++; if (bus_addr !== 32'hC000_0004 || bus_wdata !== 32'h55) begin n_bad++; $display("FAIL io_hold: cycle %0d got %h/%h want c0000004/55", k, bus_addr, bus_wdata); end
      n_cmp++; if (m1_rvalid !== 1'b0) begin n_bad++; $display("FAIL io_early_rvalid: cycle %0d got %b want 0", k, m1_rvalid); end
    end
    @(negedge clk); #1;
    n_cmp++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h0 || m1_err !== 1'b0) begin n_bad++; $display("FAIL io_resp: got %b/%h/%b want 1/0/0", m1_rvalid, m1_rdata, m1_err); end
    n_cmp++; if (m0_gnt !== 1'b1) begin n_bad++; $display("FAIL io_regrant: got %b want 1", m0_gnt); end
    @(negedge clk);
    m0_req = 1'b0; #1;
    n_cmp++; if (m0_rvalid !== 1'b1 || m0_rdata !== model_mem[0]) begin n_bad++; $display("FAIL io_next_resp: got %b/%h want 1/%h", m0_rvalid, m0_rdata, model_mem[0]); end
  endtask

  task automatic test_unmapped;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      m0_req = 1'b1; m0_we = (k == 1); m0_addr = (k == 0) ? 32'h4000_0000 : 32'h8000_0008; m0_wdata = 32'h77; #1;
      n_cmp++; if ({m0_gnt, ram_we, bus_we} !== 3'b100) begin n_bad++; $display("FAIL um_grant: case %0d got %b want 100", k, {m0_gnt, ram_we, bus_we}); end
      @(negedge clk);
      m0_req = 1'b0; #1;
      n_cmp++; if ({m0_rvalid, m0_err} !== 2'b11 || m0_rdata !== 32'h0) begin n_bad++; $display("FAIL um_resp: case %0d got %b/%h want 11/0", k, {m0_rvalid, m0_err}, m0_rdata); end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    for (int k = 0; k <= 4; k++) begin
      m0_req = (k < 4); m0_we = 1'b0; m0_addr = 32'(k) * 32'd4; m1_req = 1'b0; #1;
      n_cmp++; if (m0_gnt !== (k < 4)) begin n_bad++; $display("FAIL b2b_gnt: cycle %0d got %b want %b", k, m0_gnt, k < 4); end
      if (k > 0) begin
        n_cmp++; if (m0_rvalid !== 1'b1 || m0_rdata !== model_mem[k-1]) begin n_bad++; $display("FAIL b2b_resp: cycle %0d got %b/%h want 1/%h", k, m0_rvalid, m0_rdata, model_mem[k-1]); end
      end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_tail: got %b want 0", m0_rvalid); end
  endtask

  task automatic test_reset_mid_io;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hC000_0010; #1;
    n_cmp++; if (m0_gnt !== 1'b1) begin n_bad++; $display("FAIL rio_gnt: got %b want 1", m0_gnt); end
    @(negedge clk);
    m0_req = 1'b0;
    #1 rst = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8; #1;
    n_cmp++; if ({m0_gnt, m1_gnt, ram_we, bus_we, m0_rvalid} !== 5'b0) begin n_bad++; $display("FAIL rio_in_reset: got %b want 00000", {m0_gnt, m1_gnt, ram_we, bus_we, m0_rvalid}); end
    @(negedge clk); #1;
    n_cmp++; if ({m1_gnt, m0_rvalid, m0_err} !== 3'b0) begin n_bad++; $display("FAIL rio_hold_reset: got %b want 000", {m1_gnt, m0_rvalid, m0_err}); end
    @(negedge clk);
    rst = 1'b1; init_shadow(); #1;
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01 || m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL rio_first_grant: got %b/%b want 01/0", {m0_gnt, m1_gnt}, m0_rvalid); end
    @(negedge clk);
    m1_req = 1'b0; #1;
    n_cmp++; if (m1_rvalid !== 1'b1 || m1_rdata !== model_mem[2] || m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL rio_post_resp: got %b/%h/%b want 1/%h/0", m1_rvalid, m1_rdata, m0_rvalid, model_mem[2]); end
    @(negedge clk); #1;
    n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_bad++; $display("FAIL rio_no_ghost: got %b want 00", {m0_rvalid, m1_rvalid}); end
  endtask

  // Transaction-level model: who may be granted, when each response is due, and what it carries.
  task automatic test_random;
    resp_t       q[$];
    resp_t       r;
    int          free_at, last_m, g, lat;
    logic        r_req[2], r_we[2];
    logic [31:0] r_addr[2], r_wd[2];
    logic [1:0]  quad;
    logic        exp_ram_we, exp_bus_we, is_io, is_ram;
    logic        exp_v[2], exp_e[2];
    logic [31:0] exp_d[2];
    logic [31:0] d;
    logic        e;
    apply_reset();
    free_at = 0; last_m = 1;
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!r_req[m] && $urandom_range(0, 9) < 6) begin
          r_req[m] = 1'b1; r_we[m] = 1'($urandom_range(0, 1)); r_wd[m] = $urandom;
          case ($urandom_range(0, 5))
            0, 1, 2: r_addr[m] = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            3, 4:    r_addr[m] = {2'b11, 30'($urandom)};
            default: r_addr[m] = {($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10, 30'($urandom)};
          endcase
        end
      end
      m0_req = r_req[0]; m0_we = r_we[0]; m0_addr = r_addr[0]; m0_wdata = r_wd[0];
      m1_req = r_req[1]; m1_we = r_we[1]; m1_addr = r_addr[1]; m1_wdata = r_wd[1];
      #1;
      g = -1;
      if (c >= free_at) begin
        if (r_req[0] && r_req[1]) g = (last_m == 1) ? 0 : 1;
        else if (r_req[0])        g = 0;
        else if (r_req[1])        g = 1;
      end
      exp_ram_we = 1'b0; exp_bus_we = 1'b0; is_io = 1'b0; is_ram = 1'b0;
      if (g >= 0) begin
        quad = r_addr[g][31:30];
        is_ram = (quad == 2'b00); is_io = (quad == 2'b11);
        exp_ram_we = is_ram && r_we[g];
        exp_bus_we = is_io && r_we[g];
      end
      n_cmp++; if ({m0_gnt, m1_gnt} !== {g == 0, g == 1}) begin n_bad++; $display("FAIL rnd_gnt: cyc %0d got %b want %b", c, {m0_gnt, m1_gnt}, {g == 0, g == 1}); end
      n_cmp++; if ({ram_we, bus_we} !== {exp_ram_we, exp_bus_we}) begin n_bad++; $display("FAIL rnd_we: cyc %0d got %b want %b", c, {ram_we, bus_we}, {exp_ram_we, exp_bus_we}); end
      exp_v[0] = 1'b0; exp_v[1] = 1'b0; exp_e[0] = 1'b0; exp_e[1] = 1'b0; exp_d[0] = '0; exp_d[1] = '0;
      if (q.size() > 0 && q[0].due == c) begin
        r = q.pop_front();
        exp_v[r.m] = 1'b1; exp_d[r.m] = r.data; exp_e[r.m] = r.err;
      end
      n_cmp++; if ({m0_rvalid, m1_rvalid} !== {exp_v[0], exp_v[1]}) begin n_bad++; $display("FAIL rnd_rvalid: cyc %0d got %b want %b", c, {m0_rvalid, m1_rvalid}, {exp_v[0], exp_v[1]}); end
      n_cmp++; if (m0_rdata !== exp_d[0] || m1_rdata !== exp_d[1]) begin n_bad++; $display("FAIL rnd_rdata: cyc %0d got %h/%h want %h/%h", c, m0_rdata, m1_rdata, exp_d[0], exp_d[1]); end
      n_cmp++; if ({m0_err, m1_err} !== {exp_e[0], exp_e[1]}) begin n_bad++; $display("FAIL rnd_err: cyc %0d got %b want %b", c, {m0_err, m1_err}, {exp_e[0], exp_e[1]}); end
      if (g >= 0) begin
        lat = is_io ? IO_WAIT + 1 : 1;
        d = '0; e = !(is_io || is_ram);
        if (is_ram && r_we[g])  model_mem[r_addr[g][5:2]] = r_wd[g];
        if (is_ram && !r_we[g]) d = model_mem[r_addr[g][5:2]];
        if (is_io && !r_we[g])  d = io_value(r_addr[g]);
        q.push_back('{due: c + lat, m: g, data: d, err: e});
        free_at = c + lat; last_m = g; r_req[g] = 1'b0;
      end
      @(negedge clk);
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_tie();
    test_io_write();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_io();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 Parameter IO_WAIT, default 2, extra wait cycles per IO-region access (0..15).
REQ-002 Parameter DATA_W, default 32, data width of all data ports.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low; released synchronously to clk externally.
REQ-005 m0_req, m1_req  input  1 each  transfer request; m0 = CPU data port, m1 = DMA/loader.
REQ-006 m0_we, m1_we  input  1 each  1 = write, 0 = read.
REQ-007 m0_addr, m1_addr  input  32 each  byte address.
REQ-008 m0_wdata, m1_wdata  input  DATA_W each  write data.
REQ-009 m0_gnt, m1_gnt  output  1 each  request accepted this cycle (combinational).
REQ-010 m0_rvalid, m1_rvalid  output  1 each  one-cycle response pulse per accepted transfer.
REQ-011 m0_rdata, m1_rdata / m0_err, m1_err  output  DATA_W / 1  response data; unmapped-address flag.
REQ-012 ram_we, ram_addr[31:0], ram_wdata  output  RAM strobe/address/data; ram_rdata  input  DATA_W, 1-cycle read latency.
REQ-013 bus_we, bus_addr[31:0], bus_wdata  output  IO bus strobe/address/data; bus_rdata  input  DATA_W, 1-cycle latency after address.

Function
REQ-014 Region = addr & QUAD_MASK: equal RAM_BASE_ADDR -> RAM; equal IO_BASE_ADDR -> IO; otherwise unmapped.
REQ-015 FSM states IDLE and IO_WAIT; grants issued only in IDLE; gnt both 0 in IO_WAIT.
REQ-016 In IDLE, single requester is granted in the same cycle; at most one gnt high per cycle.
REQ-017 Both requesting in IDLE: grant the master not granted last (round-robin pointer); pointer updates only on a grant.
REQ-018 Granted cycle T: selected master's addr/wdata drive the target region's port combinationally; ram_we/bus_we = we of granted master, asserted in cycle T only.
REQ-019 Non-target strobes stay 0; unmapped transfers drive no strobe.
REQ-020 RAM or unmapped transfer: rvalid to granted master at T+1, state stays IDLE.
REQ-021 IO transfer with IO_WAIT>0: next state IO_WAIT, down-counter loaded with IO_WAIT; bus_addr/bus_wdata held from registered copies through T+IO_WAIT; return to IDLE when counter reaches 1; rvalid at T+IO_WAIT+1.
REQ-022 IO_WAIT=0: IO transfers behave as REQ-020 timing.
REQ-023 Response steering uses owner and region registered at grant: rdata = ram_rdata (RAM read) or bus_rdata (IO read); 0 for writes and unmapped; err = 1 only for unmapped.
REQ-024 Non-owner rdata = 0, rvalid = 0, err = 0.
REQ-025 A new grant is permitted in the same cycle as a rvalid pulse (back-to-back throughput one RAM transfer per cycle).
REQ-026 Requests not granted are not stored; masters hold req/addr/we/wdata until gnt.

Reset
REQ-027 On rst low: state IDLE, counter 0, rvalid both 0, err 0, round-robin pointer = m1 (m0 wins first tie), owner/region registers 0.
REQ-028 While rst low: all gnt, ram_we, bus_we = 0.
REQ-029 Reset mid-transfer aborts it; no rvalid is produced for the aborted transfer after release.

Structure
REQ-030 QUAD_MASK (0xC000_0000), RAM_BASE_ADDR (0x0000_0000), IO_BASE_ADDR (0xC000_0000) live in the shared reg_map header; region encoding (RAM, IO, UNMAPPED) also defined there.
REQ-031 Two-requester round-robin grant logic is a sub-module rr_arbiter2 (req[1:0], enable, gnt[1:0], pointer state).
REQ-032 FSM, wait counter, address hold registers and response steering reside in data_bus_arbiter.

Verification
REQ-033 m0 reads 0x0000_0010 alone, RAM returns 0xDEADBEEF -> m0_gnt at T, ram_addr=0x10, m0_rvalid and m0_rdata=0xDEADBEEF at T+1, m1 outputs 0.
REQ-034 m0 and m1 request RAM simultaneously after reset -> m0 granted T, m1 granted T+1, m0 again first on next tie only if m1 was last.
REQ-035 m1 writes 0xC000_0004 data 0x55 with IO_WAIT=2 -> bus_we pulse at T only, bus_addr held T..T+2, no grants T+1..T+2, m1_rvalid at T+3, rdata 0.
REQ-036 m0 reads 0x4000_0000 -> no ram_we/bus_we, m0_rvalid and m0_err=1 at T+1, rdata 0.
REQ-037 m0 issues 4 back-to-back RAM reads -> gnt every cycle, four rvalids on consecutive cycles T+1..T+4, data in order.
REQ-038 rst asserted during IO_WAIT of an IO read -> state IDLE immediately, no rvalid after release, first post-reset request granted in its cycle.
